// File: rtl/char_buffer_writer.sv
// char_buffer_writer: places an ASCII byte stream into a COLS x ROWS character
// RAM at a moving cursor. It also answers the overlay renderer's char_xy lookups
// with one cycle of latency.
module char_buffer_writer #(
  parameter int         COLS  = 8,
  parameter int         ROWS  = 32,
  parameter logic [6:0] BLANK = 7'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] char_xy,
  output logic [6:0] char_code,
  output logic [7:0] cursor_xy,
  output logic       busy
);

  localparam int DEPTH = COLS * ROWS;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

  // Control characters that the decoder handles
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic {CLEAR, IDLE} state_t;

  typedef struct packed {
    logic [RW-1:0] row;
    logic [CW-1:0] col;
  } cursor_t;

  // Write-port request produced by the decoder
  typedef struct packed {
    logic       en;
    logic [7:0] addr;
    logic [6:0] data;
  } wr_req_t;

  state_t     state, state_n;
  logic [7:0] clear_addr, clear_addr_n;
  cursor_t    cur, cur_n;
  wr_req_t    wr;

  logic [6:0] mem [0:DEPTH-1];

  logic          accept;
  logic          printable;
  logic [CW-1:0] col_inc;
  logic [RW-1:0] row_inc;
  logic          col_last;

  assign in_ready  = (state == IDLE);
  assign busy      = (state == CLEAR);
  assign accept    = in_valid & in_ready;
  assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);

  // Cursor index is formed only from registered col/row, so it holds the
  // position left behind by the last accepted byte.
  assign cursor_xy = 8'(int'(cur.col) + COLS * int'(cur.row));

  // Wrapping increments. The row wraps to 0 after the last row because this
  // block does not scroll.
  assign col_last = (cur.col == CW'(COLS - 1));
  assign col_inc  = col_last ? '0 : cur.col + 1'b1;
  assign row_inc  = (cur.row == RW'(ROWS - 1)) ? '0 : cur.row + 1'b1;

  // State, sweep address and cursor registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      clear_addr <= '0;
      cur        <= '0;
    end else begin
      state      <= state_n;
      clear_addr <= clear_addr_n;
      cur        <= cur_n;
    end
  end

  // Next-state logic: clear sweep, byte decode and cursor movement
  always_comb begin
    state_n      = state;
    clear_addr_n = clear_addr;
    cur_n        = cur;
    wr.en        = 1'b0;
    wr.addr      = clear_addr;
    wr.data      = BLANK;
    case (state)
      CLEAR: begin
        wr.en        = 1'b1;
        clear_addr_n = clear_addr + 8'd1;
        if (clear_addr == 8'(DEPTH - 1)) begin
          state_n = IDLE;
          cur_n   = '0;
        end
      end
      IDLE: begin
        if (accept) begin
          if (printable) begin
            wr.en     = 1'b1;
            wr.addr   = cursor_xy;
            wr.data   = in_data[6:0];
            cur_n.col = col_inc;
            if (col_last) cur_n.row = row_inc;
          end else begin
            case (in_data)
              CH_CR: cur_n.col = '0;
              CH_LF: cur_n.row = row_inc;
              CH_BS: begin
                // At column 0 backspace does nothing. It never wraps back to
                // the previous row.
                if (cur.col != '0) begin
                  cur_n.col = cur.col - 1'b1;
                  wr.en     = 1'b1;
                  wr.addr   = cursor_xy - 8'd1;
                  wr.data   = BLANK;
                end
              end
              CH_FF: begin
                state_n      = CLEAR;
                clear_addr_n = '0;
              end
              default: ;
            endcase
          end
        end
      end
      default: state_n = CLEAR;
    endcase
  end

  // RAM write port. Reset suppresses the write so an interrupted byte or sweep
  // leaves no trace.
  always_ff @(posedge clk) begin
    if (wr.en && !rst) mem[wr.addr] <= wr.data;
  end

  // RAM read port. Its nonblocking read samples the old cell contents, so a
  // same-cycle read and write returns the old data.
  always_ff @(posedge clk) begin
    if (rst)
      char_code <= BLANK;
    else if (int'(char_xy) >= DEPTH)
      char_code <= BLANK;
    else
      char_code <= mem[char_xy];
  end

endmodule

// File: tb/tb_char_buffer_writer.sv
// Directed bench for char_buffer_writer with hand-computed expectations
// (COLS=8, ROWS=32, BLANK=0x20).
module tb_char_buffer_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] char_xy;
  logic [6:0] char_code;
  logic [7:0] cursor_xy;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  char_buffer_writer dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .char_xy   (char_xy),
    .char_code (char_code),
    .cursor_xy (cursor_xy),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [6:0] exp, input string tag);
    char_xy = a;
    tick();
    chk(tag, 32'(char_code), 32'(exp));
  endtask

  // Count sampled cycles with busy high, bounded; in_valid is dropped on exit
  // so a held byte is never accepted.
  task automatic busy_len(output int cnt, output int leak);
    cnt  = 0;
    leak = 0;
    while (busy && cnt < 400) begin
      if (in_ready) leak++;
      cnt++;
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int cnt, leak, bad;
    rst      = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    char_xy  = 8'd0;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_char_code", 32'(char_code), 32'h20);
    chk("rst_cursor", 32'(cursor_xy), 32'd0);

    // 1: release reset with a byte already waiting
    rst      = 1'b0;
    in_data  = 8'h41;
    in_valid = 1'b1;
    cnt = 0;
    while (!in_ready && cnt < 400) begin
      cnt++;
      tick();
    end
    chk("init_sweep_len", 32'(cnt), 32'd256);
    tick();
    in_valid = 1'b0;
    chk("first_cursor", 32'(cursor_xy), 32'd1);
    rd(8'd0, 7'h41, "first_mem0");
    rd(8'd5, 7'h20, "blank_mem5");

    // Back up to the origin so the next string starts at cell 0
    send(8'h08);
    chk("bs_to_0", 32'(cursor_xy), 32'd0);
    rd(8'd0, 7'h20, "bs_blank0");

    // 2: "ABCDEFGHI" back-to-back, wrapping from col 7 to row 1
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      in_data  = 8'h41 + 8'(i);
      in_valid = 1'b1;
      if (!in_ready) bad++;
      tick();
    end
    in_valid = 1'b0;
    chk("b2b_stalls", 32'(bad), 32'd0);
    chk("b2b_cursor", 32'(cursor_xy), 32'd9);
    rd(8'd7, 7'h48, "b2b_mem7");
    rd(8'd8, 7'h49, "b2b_mem8");
    rd(8'd0, 7'h41, "b2b_mem0");

    // 3: CR, LF, ignored codes, then the wrap from cell 255 to cell 0
    send(8'h4A);
    chk("cursor10", 32'(cursor_xy), 32'd10);
    send(8'h0D);
    chk("cr_cursor", 32'(cursor_xy), 32'd8);
    send(8'h0A);
    chk("lf_cursor", 32'(cursor_xy), 32'd16);
    send(8'h07);
    send(8'h7F);
    send(8'h1B);
    chk("ignored_cursor", 32'(cursor_xy), 32'd16);
    rd(8'd16, 7'h20, "ignored_mem16");
    for (int i = 0; i < 29; i++) send(8'h0A);
    chk("lf_row31", 32'(cursor_xy), 32'd248);
    for (int i = 0; i < 7; i++) send(8'h7E);
    chk("cursor255", 32'(cursor_xy), 32'd255);
    send(8'h41);
    chk("wrap_cursor", 32'(cursor_xy), 32'd0);
    rd(8'd255, 7'h41, "wrap_mem255");
    rd(8'd254, 7'h7E, "tilde_mem254");

    // 4: backspace, including the no-op at column 0
    send(8'h41);
    send(8'h42);
    chk("ab_cursor", 32'(cursor_xy), 32'd2);
    send(8'h08);
    chk("bs1_cursor", 32'(cursor_xy), 32'd1);
    rd(8'd1, 7'h20, "bs1_mem1");
    send(8'h08);
    chk("bs2_cursor", 32'(cursor_xy), 32'd0);
    rd(8'd0, 7'h20, "bs2_mem0");
    send(8'h08);
    chk("bs3_cursor", 32'(cursor_xy), 32'd0);
    rd(8'd255, 7'h41, "bs3_no_rev_wrap");

    // 6a: read-first on a same-cycle read and write at cell 3 (which holds 'D')
    send(8'h31);
    send(8'h32);
    send(8'h33);
    chk("rf_cursor", 32'(cursor_xy), 32'd3);
    char_xy  = 8'd3;
    in_data  = 8'h5A;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rf_old", 32'(char_code), 32'h44);
    tick();
    chk("rf_new", 32'(char_code), 32'h5A);

    // 5: form feed starts a sweep one cycle after the accept; a held byte waits
    in_data  = 8'h0C;
    in_valid = 1'b1;
    tick();
    chk("ff_busy", 32'(busy), 32'd1);
    chk("ff_in_ready", 32'(in_ready), 32'd0);
    in_data = 8'h55;
    busy_len(cnt, leak);
    chk("ff_sweep_len", 32'(cnt), 32'd256);
    chk("ff_ready_leak", 32'(leak), 32'd0);
    chk("ff_cursor", 32'(cursor_xy), 32'd0);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      char_xy = 8'(i);
      tick();
      if (char_code !== 7'h20) bad++;
    end
    chk("ff_all_blank", 32'(bad), 32'd0);
    chk("ff_no_accept", 32'(cursor_xy), 32'd0);

    // 6b: reset in the middle of a sweep restarts a full sweep from address 0
    send(8'h41);
    send(8'h0C);
    for (int i = 0; i < 100; i++) tick();
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_code", 32'(char_code), 32'h20);
    chk("mid_rst_cursor", 32'(cursor_xy), 32'd0);
    busy_len(cnt, leak);
    chk("mid_rst_sweep_len", 32'(cnt), 32'd256);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
